// File: rtl/pc_sequencer.sv
// Registered next-PC engine: sequential, conditional-relative, absolute jump, call/return via a circular return stack.
// Optional macro PC_STACK_GUARD_EN turns stack overflow/underflow into a sticky stack_err fault instead of wrap/ignore.
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int IMM_W       = 6,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic [2:0]                         bs,
  input  logic                               z,
  input  logic                               n,
  input  logic [IMM_W-1:0]                   imm,
  input  logic [ADDR_W-1:0]                  jump_addr,
  output logic [ADDR_W-1:0]                  pc,
  output logic [ADDR_W-1:0]                  pc_prev,
  output logic                               taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_count,
  output logic                               stack_err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH+1);

  localparam logic [2:0] BS_INC  = 3'b000;
  localparam logic [2:0] BS_BZ   = 3'b001;
  localparam logic [2:0] BS_BNZ  = 3'b010;
  localparam logic [2:0] BS_BN   = 3'b011;
  localparam logic [2:0] BS_JMP  = 3'b100;
  localparam logic [2:0] BS_CALL = 3'b101;
  localparam logic [2:0] BS_RET  = 3'b110;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_prev;
  logic              r_taken;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_top;     // slot the next push writes; wraps so a full push overwrites the oldest
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_rel;
  logic [ADDR_W-1:0] w_next;
  logic              w_taken;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W-1:0]  w_top_m1;
  logic [PTR_W-1:0]  w_top_p1;
  logic              w_update;

  assign w_update = !rst && !stall;
  assign w_full   = (r_count == CNT_W'(STACK_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_top_m1 = (r_top == '0) ? PTR_W'(STACK_DEPTH-1) : r_top - 1'b1;
  assign w_top_p1 = (r_top == PTR_W'(STACK_DEPTH-1)) ? '0 : r_top + 1'b1;
  assign w_seq    = r_pc + 1'b1;
  assign w_rel    = r_pc + w_imm_ext;

  always_comb begin
    w_imm_ext = {ADDR_W{imm[IMM_W-1]}};
    w_imm_ext[IMM_W-1:0] = imm;
  end

`ifdef PC_STACK_GUARD_EN
  logic w_err;
  logic r_err;
`endif

  always_comb begin
    w_next  = w_seq;
    w_taken = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
`ifdef PC_STACK_GUARD_EN
    w_err   = 1'b0;
`endif
    case (bs)
      BS_BZ:  if (z)  begin w_next = w_rel; w_taken = 1'b1; end
      BS_BNZ: if (!z) begin w_next = w_rel; w_taken = 1'b1; end
      BS_BN:  if (n)  begin w_next = w_rel; w_taken = 1'b1; end
      BS_JMP: begin w_next = jump_addr; w_taken = 1'b1; end
      BS_CALL: begin
`ifdef PC_STACK_GUARD_EN
        if (w_full) begin
          w_err = 1'b1;
        end else begin
          w_push  = 1'b1;
          w_next  = jump_addr;
          w_taken = 1'b1;
        end
`else
        w_push  = 1'b1;
        w_next  = jump_addr;
        w_taken = 1'b1;
`endif
      end
      BS_RET: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_next  = r_stack[w_top_m1];
          w_taken = 1'b1;
        end
`ifdef PC_STACK_GUARD_EN
        else begin
          w_err = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= ADDR_W'(RESET_PC);
      r_pc_prev <= ADDR_W'(RESET_PC);
      r_taken   <= 1'b0;
      r_count   <= '0;
      r_top     <= '0;
    end else if (!stall) begin
      r_pc      <= w_next;
      r_pc_prev <= r_pc;
      r_taken   <= w_taken;
      if (w_push) begin
        r_top <= w_top_p1;
        if (!w_full) r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_top   <= w_top_m1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Stack contents need no reset; only the pointer and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_update && w_push) r_stack[r_top] <= w_seq;
  end

`ifdef PC_STACK_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst)                   r_err <= 1'b0;
    else if (!stall && w_err)  r_err <= 1'b1;
  end
  assign stack_err = r_err;
`else
  assign stack_err = 1'b0;
`endif

  assign pc       = r_pc;
  assign pc_prev  = r_pc_prev;
  assign taken    = r_taken;
  assign sp_count = r_count;

endmodule
